// File: rtl/multicycle_control.sv
// multicycle_control
// Multicycle control FSM for the RV32I datapath. Sequences one instruction at
// a time through fetch, decode, execute, memory and writeback, and drives the
// LOAD strobes of the datapath registers plus the register-file, memory and
// mux selects.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   opcode_i       IR[6:0] from the IR register output
//   mem_ready_i    memory finished the current read/write this cycle
//   br_taken_i     ALU branch-condition result
//   *_load_o       one-cycle LOAD strobes for PC, IR(+OLD_PC), A/B, ALUOut, MDR
//   rf_write_o     register-file write enable
//   mem_read_o / mem_write_o  memory request
//   addr_src_o     memory address: 0=PC, 1=ALUOut
//   alu_src_a_o    00=PC, 01=A, 10=OLD_PC, 11=zero
//   alu_src_b_o    00=B, 01=const 4, 10=imm
//   alu_op_o       00=add, 01=branch compare, 10=funct-decoded
//   wb_sel_o       00=ALUOut, 01=MDR, 10=PC
//   pc_src_o       PC input: 0=ALU result, 1=ALUOut
//   state_o        current state code (debug)
//   trap_o         illegal-opcode flag
//
// Build option: define CTRL_TRAP_EN to send illegal opcodes to a sticky TRAP
// state; otherwise illegal opcodes execute as a NOP and trap_o stays 0.

module multicycle_control #(
    parameter int ALUOP_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [6:0]         opcode_i,
    input  logic               mem_ready_i,
    input  logic               br_taken_i,
    output logic               pc_load_o,
    output logic               ir_load_o,
    output logic               ab_load_o,
    output logic               aluout_load_o,
    output logic               mdr_load_o,
    output logic               rf_write_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               addr_src_o,
    output logic [1:0]         alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [1:0]         wb_sel_o,
    output logic               pc_src_o,
    output logic [3:0]         state_o,
    output logic               trap_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMRD     = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWR     = 4'd5,
        S_EXEC      = 4'd6,
        S_ALUWB     = 4'd7,
        S_BRANCH    = 4'd8,
        S_JAL       = 4'd9,
        S_JALR_ADDR = 4'd10,
        S_JALR      = 4'd11,
        S_TRAP      = 4'd15
    } state_e;

    state_e     state_q, state_d;
    // EXEC operand selects are decided in DECODE, so the opcode only needs
    // to be looked at in DECODE and MEMADR.
    logic [1:0] exec_a_q, exec_a_d, exec_b_q, exec_b_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_FETCH;
            exec_a_q <= 2'b00;
            exec_b_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            exec_a_q <= exec_a_d;
            exec_b_q <= exec_b_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        exec_a_d      = exec_a_q;
        exec_b_d      = exec_b_q;
        pc_load_o     = 1'b0;
        ir_load_o     = 1'b0;
        ab_load_o     = 1'b0;
        aluout_load_o = 1'b0;
        mdr_load_o    = 1'b0;
        rf_write_o    = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        addr_src_o    = 1'b0;
        alu_src_a_o   = 2'b00;
        alu_src_b_o   = 2'b00;
        alu_op_o      = '0;
        wb_sel_o      = 2'b00;
        pc_src_o      = 1'b0;
        trap_o        = 1'b0;
        state_o       = state_q;

        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                if (mem_ready_i) begin
                    ir_load_o = 1'b1;
                    pc_load_o = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut captures OLD_PC + imm, the branch/JAL target.
                ab_load_o     = 1'b1;
                aluout_load_o = 1'b1;
                alu_src_a_o   = 2'b10;
                alu_src_b_o   = 2'b10;
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG:    begin state_d = S_EXEC; exec_a_d = 2'b01; exec_b_d = 2'b00; end
                    OP_IMM:    begin state_d = S_EXEC; exec_a_d = 2'b01; exec_b_d = 2'b10; end
                    OP_LUI:    begin state_d = S_EXEC; exec_a_d = 2'b11; exec_b_d = 2'b10; end
                    OP_AUIPC:  begin state_d = S_EXEC; exec_a_d = 2'b10; exec_b_d = 2'b10; end
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR_ADDR;
                    OP_FENCE, OP_SYSTEM: state_d = S_FETCH;
`ifdef CTRL_TRAP_EN
                    default:   state_d = S_TRAP;
`else
                    default:   state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                aluout_load_o = 1'b1;
                alu_src_a_o   = 2'b01;
                alu_src_b_o   = 2'b10;
                state_d       = (opcode_i == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read_o = 1'b1;
                addr_src_o = 1'b1;
                if (mem_ready_i) begin
                    mdr_load_o = 1'b1;
                    state_d    = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_write_o = 1'b1;
                wb_sel_o   = 2'b01;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_o = 1'b1;
                addr_src_o  = 1'b1;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_EXEC: begin
                aluout_load_o = 1'b1;
                alu_op_o      = ALUOP_W'(2'b10);
                alu_src_a_o   = exec_a_q;
                alu_src_b_o   = exec_b_q;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                rf_write_o = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                // ALU compares A vs B; PC takes the target held in ALUOut.
                alu_src_a_o = 2'b01;
                alu_op_o    = ALUOP_W'(2'b01);
                pc_src_o    = 1'b1;
                pc_load_o   = br_taken_i;
                state_d     = S_FETCH;
            end
            S_JAL, S_JALR: begin
                rf_write_o = 1'b1;
                wb_sel_o   = 2'b10;
                pc_load_o  = 1'b1;
                pc_src_o   = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR_ADDR: begin
                aluout_load_o = 1'b1;
                alu_src_a_o   = 2'b01;
                alu_src_b_o   = 2'b10;
                state_d       = S_JALR;
            end
`ifdef CTRL_TRAP_EN
            S_TRAP: begin
                trap_o  = 1'b1;
                state_d = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        // Outputs are forced quiet for the whole reset window, even before
        // the first edge has put the state register into FETCH.
        if (rst_i) begin
            pc_load_o     = 1'b0;
            ir_load_o     = 1'b0;
            ab_load_o     = 1'b0;
            aluout_load_o = 1'b0;
            mdr_load_o    = 1'b0;
            rf_write_o    = 1'b0;
            mem_read_o    = 1'b0;
            mem_write_o   = 1'b0;
            addr_src_o    = 1'b0;
            alu_src_a_o   = 2'b00;
            alu_src_b_o   = 2'b00;
            alu_op_o      = '0;
            wb_sel_o      = 2'b00;
            pc_src_o      = 1'b0;
            trap_o        = 1'b0;
            state_o       = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: builds a per-cycle plan of inputs and
// expected outputs from the instruction-level rules, then replays it.
module tb_multicycle_control;

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011,
                           RI = 7'b0010011, LU = 7'b0110111, AU = 7'b0010111,
                           BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111,
                           FE = 7'b0001111, SY = 7'b1110011;

    typedef struct packed {
        logic       pc_load, ir_load, ab_load, aluout_load, mdr_load;
        logic       rf_write, mem_read, mem_write, addr_src;
        logic [1:0] src_a, src_b, alu_op, wb_sel;
        logic       pc_src, trap;
    } out_t;

    typedef struct {
        logic       rst;
        logic [6:0] opc;
        logic       rdy, br;
        logic [3:0] st;
        out_t       o;
    } cyc_t;

    logic clk = 1'b0, rst = 1'b1, rdy = 1'b0, br = 1'b0;
    logic [6:0] opc = 7'd0;
    logic pc_load, ir_load, ab_load, aluout_load, mdr_load, rf_write;
    logic mem_read, mem_write, addr_src, pc_src, trap;
    logic [1:0] src_a, src_b, alu_op, wb_sel;
    logic [3:0] state;

    cyc_t plan[$];
    int   n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control #(.ALUOP_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opc), .mem_ready_i(rdy), .br_taken_i(br),
        .pc_load_o(pc_load), .ir_load_o(ir_load), .ab_load_o(ab_load),
        .aluout_load_o(aluout_load), .mdr_load_o(mdr_load), .rf_write_o(rf_write),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .addr_src_o(addr_src),
        .alu_src_a_o(src_a), .alu_src_b_o(src_b), .alu_op_o(alu_op),
        .wb_sel_o(wb_sel), .pc_src_o(pc_src), .state_o(state), .trap_o(trap)
    );

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic r, input logic [6:0] op, input logic rd,
                        input logic b, input logic [3:0] st, input out_t o);
        cyc_t c;
        c.rst = r; c.opc = op; c.rdy = rd; c.br = b; c.st = st; c.o = o;
        plan.push_back(c);
    endtask

    task automatic add_reset(input logic [6:0] op);
        push(1'b1, op, rb(), rb(), 4'd0, '0);
    endtask

    task automatic add_fetch(input logic [6:0] op, input int w);
        out_t o;
        o = '0; o.mem_read = 1'b1; o.src_b = 2'b01;
        repeat (w) push(1'b0, op, 1'b0, rb(), 4'd0, o);
        o.ir_load = 1'b1; o.pc_load = 1'b1;
        push(1'b0, op, 1'b1, rb(), 4'd0, o);
    endtask

    // bmode: 0/1 forces BR_TAKEN in BRANCH, 2 randomises it.
    task automatic add_instr(input logic [6:0] op, input int wf, input int wm, input int bmode);
        out_t o;
        logic b;
        add_fetch(op, wf);
        o = '0; o.ab_load = 1'b1; o.aluout_load = 1'b1; o.src_a = 2'b10; o.src_b = 2'b10;
        push(1'b0, op, rb(), rb(), 4'd1, o);
        case (op)
            LD, ST: begin
                o = '0; o.aluout_load = 1'b1; o.src_a = 2'b01; o.src_b = 2'b10;
                push(1'b0, op, rb(), rb(), 4'd2, o);
                o = '0; o.addr_src = 1'b1;
                if (op == LD) begin
                    o.mem_read = 1'b1;
                    repeat (wm) push(1'b0, op, 1'b0, rb(), 4'd3, o);
                    o.mdr_load = 1'b1;
                    push(1'b0, op, 1'b1, rb(), 4'd3, o);
                    o = '0; o.rf_write = 1'b1; o.wb_sel = 2'b01;
                    push(1'b0, op, rb(), rb(), 4'd4, o);
                end else begin
                    o.mem_write = 1'b1;
                    repeat (wm) push(1'b0, op, 1'b0, rb(), 4'd5, o);
                    push(1'b0, op, 1'b1, rb(), 4'd5, o);
                end
            end
            RR, RI, LU, AU: begin
                o = '0; o.aluout_load = 1'b1; o.alu_op = 2'b10;
                case (op)
                    RR:      begin o.src_a = 2'b01; o.src_b = 2'b00; end
                    RI:      begin o.src_a = 2'b01; o.src_b = 2'b10; end
                    LU:      begin o.src_a = 2'b11; o.src_b = 2'b10; end
                    default: begin o.src_a = 2'b10; o.src_b = 2'b10; end
                endcase
                push(1'b0, op, rb(), rb(), 4'd6, o);
                o = '0; o.rf_write = 1'b1;
                push(1'b0, op, rb(), rb(), 4'd7, o);
            end
            BR: begin
                b = (bmode == 2) ? rb() : 1'(bmode);
                o = '0; o.src_a = 2'b01; o.alu_op = 2'b01; o.pc_src = 1'b1; o.pc_load = b;
                push(1'b0, op, rb(), b, 4'd8, o);
            end
            JL, JR: begin
                if (op == JR) begin
                    o = '0; o.aluout_load = 1'b1; o.src_a = 2'b01; o.src_b = 2'b10;
                    push(1'b0, op, rb(), rb(), 4'd10, o);
                end
                o = '0; o.rf_write = 1'b1; o.wb_sel = 2'b10; o.pc_load = 1'b1; o.pc_src = 1'b1;
                push(1'b0, op, rb(), rb(), (op == JL) ? 4'd9 : 4'd11, o);
            end
            FE, SY: ;
            default: begin
`ifdef CTRL_TRAP_EN
                o = '0; o.trap = 1'b1;
                repeat (10) push(1'b0, op, rb(), rb(), 4'd15, o);
                add_reset(op);
`endif
            end
        endcase
    endtask

    initial begin
        logic [6:0] legal [11];
        cyc_t c;
        out_t act;
        int   k;
        legal = '{LD, ST, RR, RI, LU, AU, BR, JL, JR, FE, SY};

        // reset, then the directed cases
        add_reset(RR); add_reset(RR);
        add_instr(RR, 0, 0, 2);
        add_instr(LD, 0, 2, 2);
        add_instr(BR, 0, 0, 1);
        add_instr(BR, 0, 0, 0);
        add_instr(ST, 0, 0, 2);
        add_instr(JL, 0, 0, 2);
        add_instr(JR, 0, 0, 2);
        add_instr(LU, 1, 0, 2);
        add_instr(AU, 0, 0, 2);
        add_instr(RI, 0, 0, 2);
        add_instr(FE, 0, 0, 2);
        add_instr(SY, 0, 0, 2);
        // reset while MEMWR is waiting: back to FETCH, no write afterwards
        add_instr(ST, 0, 2, 2);
        void'(plan.pop_back());
        add_reset(ST);
        add_fetch(RR, 1);
        void'(plan.pop_back());
        // reset while MEMRD is waiting
        add_instr(LD, 0, 1, 2);
        void'(plan.pop_back()); void'(plan.pop_back());
        add_reset(LD);
        // illegal opcodes
        add_instr(7'b1111111, 0, 0, 2);
        add_instr(7'b0000000, 0, 0, 2);
        // random instruction mix with random wait states
        repeat (60)
            add_instr(legal[$urandom_range(0, 10)], $urandom_range(0, 2), $urandom_range(0, 3), 2);

        k = 0;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(negedge clk);
            rst = c.rst; opc = c.opc; rdy = c.rdy; br = c.br;
            #1;
            act = '{pc_load, ir_load, ab_load, aluout_load, mdr_load, rf_write, mem_read,
                    mem_write, addr_src, src_a, src_b, alu_op, wb_sel, pc_src, trap};
            n_chk++;
            assert (state === c.st) else begin
                n_fail++;
                $error("FAIL state step=%0d opc=%b got=%0d want=%0d", k, c.opc, state, c.st);
            end
            n_chk++;
            assert (act === c.o) else begin
                n_fail++;
                $error("FAIL outputs step=%0d st=%0d opc=%b got=%h want=%h", k, c.st, c.opc, act, c.o);
            end
            k++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control FSM for the RV32I datapath. Sequences one instruction at a time through fetch, decode, execute, memory and writeback. Drives the LOAD strobes of the datapath REG instances (PC, IR, A/B, ALUOut, MDR) plus the register-file, memory and mux selects. It consumes the opcode from the IR register's OUT and is the direct upstream source of every register LOAD input.

## Interface
- ALUOP_W, 2, width of ALU_OP
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- OPCODE  in  7  IR[6:0], taken from the IR register OUT
- MEM_READY  in  1  memory completed the current read or write this cycle
- BR_TAKEN  in  1  ALU branch-condition result; funct3 is decoded in the ALU
- PC_LOAD, IR_LOAD, AB_LOAD, ALUOUT_LOAD, MDR_LOAD  out  1 each  LOAD strobes for datapath REGs; IR_LOAD also loads OLD_PC
- RF_WRITE  out  1  register-file write enable
- MEM_READ, MEM_WRITE  out  1 each  memory request
- ADDR_SRC  out  1  memory address select: 0=PC, 1=ALUOut
- ALU_SRC_A  out  2  00=PC, 01=A, 10=OLD_PC, 11=zero
- ALU_SRC_B  out  2  00=B, 01=const 4, 10=imm
- ALU_OP  out  ALUOP_W  00=add, 01=branch compare, 10=funct-decoded
- WB_SEL  out  2  00=ALUOut, 01=MDR, 10=PC
- PC_SRC  out  1  PC input: 0=ALU result, 1=ALUOut
- STATE  out  4  current state code, for debug
- TRAP  out  1  illegal-opcode flag

## Operation
State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JAL 9, JALR_ADDR 10, JALR 11, TRAP 15.

Outputs are combinational from the state, gated by MEM_READY and BR_TAKEN where noted. Any output not listed for a state is 0.

- **FETCH:** MEM_READ=1, ADDR_SRC=0, ALU_SRC_A=00, ALU_SRC_B=01, ALU_OP=00.
  - If MEM_READY: IR_LOAD=1, PC_LOAD=1, PC_SRC=0, then go to DECODE.
  - Otherwise hold FETCH with no strobes.
- **DECODE:** AB_LOAD=1, ALUOUT_LOAD=1, ALU_SRC_A=10, ALU_SRC_B=10, ALU_OP=00 (computes the branch/JAL target). Next state by OPCODE:
  - 0000011 (load) or 0100011 (store) → MEMADR
  - 0110011, 0010011, 0110111 (LUI), 0010111 (AUIPC) → EXEC
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_ADDR
  - 0001111 (FENCE) or 1110011 (SYSTEM) → FETCH, executed as NOP
  - any other opcode → illegal (see Configuration)
- **MEMADR:** ALUOUT_LOAD=1, A+imm (ALU_SRC_A=01, ALU_SRC_B=10). Next state MEMRD for a load, MEMWR for a store.
- **MEMRD:** MEM_READ=1, ADDR_SRC=1. When MEM_READY: MDR_LOAD=1, go to MEMWB.
- **MEMWB:** RF_WRITE=1, WB_SEL=01, then FETCH.
- **MEMWR:** MEM_WRITE=1, ADDR_SRC=1. When MEM_READY, go to FETCH.
- **EXEC:** ALUOUT_LOAD=1, ALU_OP=10. Operand selects by opcode:
  - R-type: A, B
  - I-ALU: A, imm
  - LUI: zero, imm
  - AUIPC: OLD_PC, imm
- **ALUWB:** RF_WRITE=1, WB_SEL=00, then FETCH.
- **BRANCH:** ALU_SRC_A=01, ALU_SRC_B=00, ALU_OP=01. PC_SRC=1 and PC_LOAD=BR_TAKEN. Then FETCH.
- **JAL:** RF_WRITE=1, WB_SEL=10, PC_LOAD=1, PC_SRC=1, then FETCH.
- **JALR_ADDR:** ALUOUT_LOAD=1, A+imm, then JALR.
- **JALR:** same outputs as JAL, then FETCH.

Boundary conditions:
- MEM_READY low in FETCH, MEMRD or MEMWR: stay in the state with MEM_READ/MEM_WRITE and ADDR_SRC held stable and all LOAD strobes 0. There is no timeout.
- MEM_READY and BR_TAKEN are ignored in states that do not use them.

## Timing
- While RST=1, every output is 0 and TRAP=0.
- Reset: the first rising edge with RST=1 forces FETCH regardless of the current state, including mid-wait in MEMRD or MEMWR.
- With zero-wait memory (MEM_READY always 1), cycles per instruction:
  - R/I-ALU, LUI, AUIPC: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 3
  - JALR: 4
  - FENCE/SYSTEM: 2
- Each memory wait cycle adds 1 cycle.
- A LOAD strobe is high for exactly one cycle per use. The datapath REG captures on the edge that ends that cycle.
- IR and OLD_PC are valid from DECODE onward. OPCODE is sampled only in DECODE and MEMADR.

## Configuration
- CTRL_TRAP_EN defined:
  - An illegal opcode in DECODE goes to TRAP.
  - In TRAP, TRAP=1 and all strobes and requests are 0.
  - TRAP is sticky until RST.
- CTRL_TRAP_EN undefined:
  - An illegal opcode goes DECODE → FETCH and is executed as a NOP.
  - The TRAP port is tied to 0 and state 15 is unreachable.

## Test plan
- RST=1 for 2 cycles, then release → STATE=0 and all outputs 0 during reset; MEM_READ=1 in the first cycle after release.
- OPCODE=0110011, MEM_READY=1 → STATE sequence 0,1,6,7,0. IR_LOAD and PC_LOAD high in cycle 0; RF_WRITE high in cycle 3 with WB_SEL=00.
- OPCODE=0000011, MEM_READY low for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0. MDR_LOAD high only in the third MEMRD cycle.
- OPCODE=1100011:
  - BR_TAKEN=1 → PC_LOAD=1, PC_SRC=1 in BRANCH.
  - BR_TAKEN=0 → PC_LOAD=0. Both cases take 3 cycles.
- RST asserted while in MEMWR with MEM_READY=0 → FETCH on the next edge, with no MEM_WRITE after reset.
- OPCODE=1111111:
  - With CTRL_TRAP_EN → STATE=15, TRAP=1 held for 10 cycles, cleared only by RST.
  - Without CTRL_TRAP_EN → sequence 0,1,0 and TRAP=0.
